// File: rtl/igbt_pulse_sched_if.sv
// rtl/igbt_pulse_sched_if.sv - config, control and gate-drive bundle of the IGBT pulse scheduler
interface igbt_pulse_sched_if #(
   parameter int CH_NUM = 5,
   parameter int CNT_W  = 24
);
   logic                cfg_we;
   logic [CNT_W-1:0]    cfg_on_time;
   logic [15:0]         cfg_dead_time;
   logic [CH_NUM-1:0]   cfg_ch_mask;
   logic [7:0]          cfg_burst;
   logic                start;
   logic                stop;
   logic                fault;
   logic                fault_clr;
   logic [CH_NUM-1:0]   IGBT;
   logic                busy;
   logic                done;
   logic                fault_latch;
   logic [2:0]          cur_ch;

   modport master (
      output cfg_we, cfg_on_time, cfg_dead_time, cfg_ch_mask, cfg_burst,
      output start, stop, fault, fault_clr,
      input  IGBT, busy, done, fault_latch, cur_ch
   );

   modport slave (
      input  cfg_we, cfg_on_time, cfg_dead_time, cfg_ch_mask, cfg_burst,
      input  start, stop, fault, fault_clr,
      output IGBT, busy, done, fault_latch, cur_ch
   );
endinterface

// File: rtl/igbt_pulse_sched.sv
// rtl/igbt_pulse_sched.sv - round-robin IGBT pulse scheduler with dead time, burst count and fault latch
module igbt_pulse_sched #(
   parameter int CH_NUM = 5,
   parameter int CNT_W  = 24
) (
   input logic               sys_clk,
   input logic               sys_rst,
   igbt_pulse_sched_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_ON     = 3'd2;
   localparam logic [2:0] S_DEAD   = 3'd3;
   localparam logic [2:0] S_FAULT  = 3'd4;

   logic [2:0]        state_q,     state_d;
   logic [CNT_W-1:0]  on_time_q,   on_time_d;
   logic [15:0]       dead_time_q, dead_time_d;
   logic [CH_NUM-1:0] mask_q,      mask_d;
   logic [7:0]        burst_q,     burst_d;
   logic [CNT_W-1:0]  on_cnt_q,    on_cnt_d;
   logic [15:0]       dead_cnt_q,  dead_cnt_d;
   logic [7:0]        rounds_q,    rounds_d;
   logic              stop_pend_q, stop_pend_d;
   logic              done_q,      done_d;
   logic [2:0]        cur_ch_q,    cur_ch_d;
   logic [CH_NUM-1:0] igbt_q,      igbt_d;

   logic       busy;
   logic       has_above;
   logic [2:0] nxt_above;
   logic [2:0] nxt_low;
   logic [2:0] nxt_ch;
   logic [2:0] hi_ch;

   assign busy = (state_q == S_SELECT) || (state_q == S_ON) || (state_q == S_DEAD);

   // Descending scans: the last hit wins, giving the lowest match.
   always_comb begin
      has_above = 1'b0;
      nxt_above = '0;
      nxt_low   = '0;
      hi_ch     = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            nxt_low = 3'(i);
            if (3'(i) > cur_ch_q) begin
               nxt_above = 3'(i);
               has_above = 1'b1;
            end
         end
      end
      for (int i = 0; i < CH_NUM; i++) begin
         if (mask_q[i]) hi_ch = 3'(i);
      end
      nxt_ch = has_above ? nxt_above : nxt_low;
   end

   always_comb begin
      state_d     = state_q;
      on_time_d   = on_time_q;
      dead_time_d = dead_time_q;
      mask_d      = mask_q;
      burst_d     = burst_q;
      on_cnt_d    = on_cnt_q;
      dead_cnt_d  = dead_cnt_q;
      rounds_d    = rounds_q;
      stop_pend_d = stop_pend_q;
      done_d      = 1'b0;
      cur_ch_d    = cur_ch_q;
      igbt_d      = igbt_q;

      if (bus.cfg_we && !busy) begin
         on_time_d   = bus.cfg_on_time;
         dead_time_d = bus.cfg_dead_time;
         mask_d      = bus.cfg_ch_mask;
         burst_d     = bus.cfg_burst;
      end

      if (busy && bus.stop) stop_pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            stop_pend_d = 1'b0;
            // A same-cycle config write or stop suppresses the start.
            if (bus.start && !bus.stop && !bus.cfg_we &&
                (mask_q != '0) && (on_time_q != '0)) begin
               state_d  = S_SELECT;
               rounds_d = '0;
               cur_ch_d = 3'(CH_NUM - 1);
            end
         end
         S_SELECT: begin
            cur_ch_d = nxt_ch;
            igbt_d   = CH_NUM'(1) << nxt_ch;
            on_cnt_d = CNT_W'(1);
            state_d  = S_ON;
         end
         S_ON: begin
            if (on_cnt_q >= on_time_q) begin
               igbt_d     = '0;
               dead_cnt_d = 16'd1;
               state_d    = S_DEAD;
            end else begin
               on_cnt_d = on_cnt_q + CNT_W'(1);
            end
         end
         S_DEAD: begin
            // A zero dead time still costs one cycle so pulses never abut.
            if (dead_cnt_q >= dead_time_q) begin
               if (cur_ch_q == hi_ch && rounds_q != 8'hFF) rounds_d = rounds_q + 8'd1;
               if (((burst_q != 8'd0) && (rounds_d == burst_q)) || stop_pend_q || bus.stop) begin
                  state_d     = S_IDLE;
                  done_d      = 1'b1;
                  stop_pend_d = 1'b0;
               end else begin
                  state_d = S_SELECT;
               end
            end else begin
               dead_cnt_d = dead_cnt_q + 16'd1;
            end
         end
         S_FAULT: begin
            igbt_d = '0;
            if (bus.fault_clr && !bus.fault) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.fault) begin
         state_d     = S_FAULT;
         igbt_d      = '0;
         done_d      = 1'b0;
         stop_pend_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         on_time_q   <= '0;
         dead_time_q <= '0;
         mask_q      <= '0;
         burst_q     <= '0;
         on_cnt_q    <= '0;
         dead_cnt_q  <= '0;
         rounds_q    <= '0;
         stop_pend_q <= 1'b0;
         done_q      <= 1'b0;
         cur_ch_q    <= '0;
         igbt_q      <= '0;
      end else begin
         state_q     <= state_d;
         on_time_q   <= on_time_d;
         dead_time_q <= dead_time_d;
         mask_q      <= mask_d;
         burst_q     <= burst_d;
         on_cnt_q    <= on_cnt_d;
         dead_cnt_q  <= dead_cnt_d;
         rounds_q    <= rounds_d;
         stop_pend_q <= stop_pend_d;
         done_q      <= done_d;
         cur_ch_q    <= cur_ch_d;
         igbt_q      <= igbt_d;
      end
   end

   assign bus.IGBT        = igbt_q & ~{CH_NUM{bus.fault}};
   assign bus.busy        = busy;
   assign bus.done        = done_q;
   assign bus.fault_latch = (state_q == S_FAULT);
   assign bus.cur_ch      = cur_ch_q;
endmodule

// File: tb/tb_igbt_pulse_sched.sv
// tb/tb_igbt_pulse_sched.sv - self-checking bench for igbt_pulse_sched
module tb_igbt_pulse_sched;
   localparam int CH = 5;
   localparam int CW = 24;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   igbt_pulse_sched_if #(.CH_NUM(CH), .CNT_W(CW)) bus ();
   igbt_pulse_sched #(.CH_NUM(CH), .CNT_W(CW)) dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] mask;
      int         on;
      int         dead;
      int         burst;
      int         exp_busy;
      int         exp_pulses;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_we = 1'b0; bus.cfg_on_time = '0; bus.cfg_dead_time = '0;
      bus.cfg_ch_mask = '0; bus.cfg_burst = '0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.fault = 1'b0; bus.fault_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic program_cfg(input logic [4:0] m, input int on, input int dead, input int burst);
      bus.cfg_we = 1'b1; bus.cfg_ch_mask = m; bus.cfg_on_time = CW'(on);
      bus.cfg_dead_time = 16'(dead); bus.cfg_burst = 8'(burst);
      next_cycle();
      bus.cfg_we = 1'b0;
   endtask

   task automatic start_pulse();
      bus.start = 1'b1;
      next_cycle();
      bus.start = 1'b0;
   endtask

   // Observes ncyc cycles from the current one; k=1 is the first cycle after start.
   task automatic measure(input int ncyc, input int exp_w, output int busy_n, output int pulses,
                          output int wbad, output int ovl, output int dones, output int rise_at);
      logic [CH-1:0] cur, prev;
      int width;
      busy_n = 0; pulses = 0; wbad = 0; ovl = 0; dones = 0; rise_at = -1;
      prev = '0; width = 0;
      for (int k = 1; k <= ncyc; k++) begin
         #1;
         cur = bus.IGBT;
         if (bus.busy) busy_n++;
         if (bus.done) dones++;
         if ($countones(cur) > 1) ovl++;
         if (cur != '0 && prev == '0) begin
            pulses++;
            if (rise_at < 0) rise_at = k;
         end
         if (cur != '0) width++;
         else if (prev != '0) begin
            if (width != exp_w) wbad++;
            width = 0;
         end
         prev = cur;
         next_cycle();
         bus.cfg_we = 1'b0;
         bus.stop   = 1'b0;
      end
   endtask

   // Reference: a run is a list of per-channel segments {select, on cycles, max(dead,1)}.
   task automatic rand_run(input int n);
      logic [4:0] m;
      logic [4:0] exp_w[$];
      int seg_end[$];
      int on, dead, burst, rounds, s, len, errs;
      bit found;
      m     = 5'($urandom_range(1, 31));
      on    = $urandom_range(1, 5);
      dead  = $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
      rounds = (burst == 0) ? 2 : burst;
      for (int r = 0; r < rounds; r++) begin
         for (int ch = 0; ch < CH; ch++) begin
            if (m[ch]) begin
               exp_w.push_back(5'd0);
               for (int c = 0; c < on; c++) exp_w.push_back(5'(1 << ch));
               for (int c = 0; c < ((dead == 0) ? 1 : dead); c++) exp_w.push_back(5'd0);
               seg_end.push_back(exp_w.size() - 1);
            end
         end
      end
      len = exp_w.size();
      s = -1;
      if (burst == 0 || $urandom_range(0, 1) == 1) begin
         s = $urandom_range(0, len - 1);
         found = 1'b0;
         for (int j = 0; j < seg_end.size(); j++) begin
            if (!found && seg_end[j] >= s) begin
               len = seg_end[j] + 1;
               found = 1'b1;
            end
         end
      end
      do_reset();
      program_cfg(m, on, dead, burst);
      start_pulse();
      errs = 0;
      for (int k = 0; k < len; k++) begin
         bus.stop = (k == s);
         #1;
         if (bus.IGBT !== exp_w[k] || bus.busy !== 1'b1 || bus.done !== 1'b0) errs++;
         next_cycle();
         bus.stop = 1'b0;
      end
      #1;
      check($sformatf("rand%0d_wave", n), 32'(errs), 32'd0);
      check($sformatf("rand%0d_end", n), 32'({bus.done, bus.busy, bus.IGBT}), 32'({1'b1, 1'b0, 5'd0}));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_n, pulses, wbad, ovl, dones, rise_at, w, other, rises1;
      bit hit, got_done, prev1;

      vecs[0] = '{5'b10101, 4, 2, 1, 21, 3};
      vecs[1] = '{5'b00001, 1, 0, 3,  9, 3};
      vecs[2] = '{5'b11111, 2, 1, 1, 20, 5};
      vecs[3] = '{5'b10000, 3, 0, 2, 10, 2};
      vecs[4] = '{5'b01010, 1, 3, 2, 20, 4};

      do_reset();
      #1;
      check("rst_outputs", 32'({bus.IGBT, bus.busy, bus.done, bus.fault_latch, bus.cur_ch}), 32'd0);
      next_cycle();

      for (int v = 0; v < 5; v++) begin
         do_reset();
         program_cfg(vecs[v].mask, vecs[v].on, vecs[v].dead, vecs[v].burst);
         start_pulse();
         measure(60, vecs[v].on, busy_n, pulses, wbad, ovl, dones, rise_at);
         check($sformatf("vec%0d_busy", v), 32'(busy_n), 32'(vecs[v].exp_busy));
         check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(vecs[v].exp_pulses));
         check($sformatf("vec%0d_width", v), 32'(wbad), 32'd0);
         check($sformatf("vec%0d_overlap", v), 32'(ovl), 32'd0);
         check($sformatf("vec%0d_done", v), 32'(dones), 32'd1);
         check($sformatf("vec%0d_rise", v), 32'(rise_at), 32'd2);
      end

      for (int n = 0; n < 20; n++) rand_run(n);

      // Stop during the second IGBT[1] pulse.
      do_reset();
      program_cfg(5'b00011, 3, 1, 0);
      start_pulse();
      rises1 = 0; hit = 1'b0; prev1 = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         #1;
         if (bus.IGBT[1] && !prev1) rises1++;
         prev1 = bus.IGBT[1];
         if (rises1 == 2) hit = 1'b1;
         next_cycle();
      end
      check("stop_reach_pulse", 32'(hit), 32'd1);
      bus.stop = 1'b1;
      w = 1; other = 0; got_done = 1'b0;
      for (int k = 0; k < 50 && !got_done; k++) begin
         #1;
         if (bus.IGBT[1]) w++;
         if (bus.IGBT[0]) other++;
         if (bus.done) got_done = 1'b1;
         next_cycle();
         bus.stop = 1'b0;
      end
      check("stop_width", 32'(w), 32'd3);
      check("stop_done", 32'(got_done), 32'd1);
      check("stop_no_more", 32'(other), 32'd0);
      #1;
      check("stop_idle", 32'({bus.busy, bus.done}), 32'd0);

      // Fault mid-ON.
      do_reset();
      program_cfg(5'b00100, 10, 1, 0);
      start_pulse();
      next_cycle();
      next_cycle();
      #1;
      check("fault_pre_on", 32'(bus.IGBT), 32'b00100);
      bus.fault = 1'b1;
      #1;
      check("fault_comb_gate", 32'(bus.IGBT), 32'd0);
      next_cycle();
      #1;
      check("fault_state", 32'({bus.fault_latch, bus.busy, bus.done, bus.IGBT}), 32'({1'b1, 1'b0, 1'b0, 5'd0}));
      bus.fault_clr = 1'b1;
      next_cycle();
      bus.fault_clr = 1'b0;
      #1;
      check("fault_clr_held", 32'(bus.fault_latch), 32'd1);
      bus.fault = 1'b0;
      next_cycle();
      bus.fault_clr = 1'b1;
      next_cycle();
      bus.fault_clr = 1'b0;
      #1;
      check("fault_cleared", 32'({bus.fault_latch, bus.busy, bus.done}), 32'd0);

      // Config write while busy is ignored.
      do_reset();
      program_cfg(5'b00001, 3, 1, 2);
      start_pulse();
      bus.cfg_we = 1'b1; bus.cfg_on_time = CW'(9);
      measure(30, 3, busy_n, pulses, wbad, ovl, dones, rise_at);
      check("busy_wr_width", 32'(wbad), 32'd0);
      check("busy_wr_pulses", 32'(pulses), 32'd2);
      start_pulse();
      measure(30, 3, busy_n, pulses, wbad, ovl, dones, rise_at);
      check("busy_wr_kept", 32'(wbad), 32'd0);
      program_cfg(5'b00000, 5, 1, 1);
      start_pulse();
      #1;
      check("zero_mask_start", 32'(bus.busy), 32'd0);
      next_cycle();
      #1;
      check("zero_mask_start2", 32'(bus.busy), 32'd0);
      next_cycle();

      // Reset mid-pulse, then config-reset and same-cycle collisions.
      do_reset();
      program_cfg(5'b01000, 8, 1, 0);
      start_pulse();
      next_cycle();
      next_cycle();
      #1;
      check("rst_pre_on", 32'(bus.IGBT), 32'b01000);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      #1;
      check("rst_mid_pulse", 32'({bus.IGBT, bus.busy, bus.cur_ch}), 32'd0);
      start_pulse();
      #1;
      check("rst_cfg_cleared", 32'(bus.busy), 32'd0);
      bus.cfg_we = 1'b1; bus.cfg_ch_mask = 5'b00010; bus.cfg_on_time = CW'(2);
      bus.cfg_dead_time = 16'd1; bus.cfg_burst = 8'd1; bus.start = 1'b1;
      next_cycle();
      bus.cfg_we = 1'b0; bus.start = 1'b0;
      #1;
      check("cfgwe_start_same", 32'(bus.busy), 32'd0);
      bus.start = 1'b1; bus.stop = 1'b1;
      next_cycle();
      bus.start = 1'b0; bus.stop = 1'b0;
      #1;
      check("stop_start_same", 32'(bus.busy), 32'd0);
      bus.stop = 1'b1;
      next_cycle();
      bus.stop = 1'b0;
      start_pulse();
      #1;
      check("start_after_idle_stop", 32'({bus.busy, bus.cur_ch}), 32'({1'b1, 3'd4}));
      measure(20, 2, busy_n, pulses, wbad, ovl, dones, rise_at);
      check("written_cfg_run", 32'({pulses[3:0], wbad[3:0], dones[3:0]}), 32'h101);
      bus.fault = 1'b1; bus.start = 1'b1;
      next_cycle();
      bus.start = 1'b0;
      #1;
      check("fault_beats_start", 32'({bus.fault_latch, bus.busy}), 32'b10);
      bus.fault = 1'b0;
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/igbt_pulse_sched.md
IGBT_PULSE_SCHED -- requirements
Module: igbt_pulse_sched

Interface
REQ-001 Parameter CH_NUM, default 5: number of IGBT channels driven.
REQ-002 Parameter CNT_W, default 24: width of the on-time counter and of cfg_on_time.
REQ-003 sys_clk  input  1  system clock, 50 MHz; the block uses this one clock only.
REQ-004 sys_rst  input  1  synchronous reset, active-high.
REQ-005 cfg_we  input  1  one-cycle strobe that writes all cfg_* values into the config registers.
REQ-006 cfg_on_time  input  CNT_W  IGBT conduction time per pulse, in sys_clk cycles.
REQ-007 cfg_dead_time  input  16  gap after each pulse before the next channel fires, in sys_clk cycles.
REQ-008 cfg_ch_mask  input  CH_NUM  per-channel enable, bit i enables IGBT[i].
REQ-009 cfg_burst  input  8  number of full rounds per run; 0 means run until stopped.
REQ-010 start  input  1  one-cycle pulse that begins a run.
REQ-011 stop  input  1  one-cycle pulse that ends a run gracefully.
REQ-012 fault  input  1  external fault level, already synchronised to sys_clk.
REQ-013 fault_clr  input  1  one-cycle pulse that leaves the FAULT state.
REQ-014 IGBT  output  CH_NUM  gate drive, one bit per channel.
REQ-015 busy  output  1  high in SELECT, ON and DEAD.
REQ-016 done  output  1  one-cycle pulse when a run ends normally.
REQ-017 fault_latch  output  1  high while in FAULT.
REQ-018 cur_ch  output  3  index of the selected or firing channel.

Function
REQ-019 The state machine SHALL have the states IDLE, SELECT, ON, DEAD and FAULT.
REQ-020 cfg_we SHALL update the config registers only when busy=0; a cfg_we while busy=1 SHALL be ignored.
REQ-021 In IDLE, start with a non-zero mask and non-zero on_time SHALL move the block to SELECT, clear the round counter and set the search origin so the lowest enabled channel is picked first.
REQ-022 A start with a zero mask or zero on_time SHALL be ignored.
REQ-023 SELECT SHALL last 1 cycle: it loads cur_ch with the next enabled channel above the previous one (wrapping CH_NUM-1 -> 0) and moves to ON.
REQ-024 ON SHALL hold IGBT[cur_ch]=1 for exactly cfg_on_time cycles, with every other IGBT bit 0, then move to DEAD.
REQ-025 IGBT SHALL rise exactly 2 cycles after the cycle in which start is sampled.
REQ-026 DEAD SHALL hold IGBT=0 for cfg_dead_time cycles; when dead_time=0, DEAD SHALL last 1 cycle, so IGBT is never high on two consecutive pulses without at least one zero cycle between them.
REQ-027 A round SHALL complete when DEAD ends for the highest enabled channel, and the round counter SHALL then increment (8-bit, saturating).
REQ-028 At the end of DEAD, if cfg_burst!=0 and the round count equals cfg_burst, or if a stop is pending, the block SHALL go to IDLE and pulse done for 1 cycle; otherwise it SHALL go to SELECT.
REQ-029 A stop seen in SELECT, ON or DEAD SHALL be latched as pending; the current pulse and its dead time SHALL complete unshortened.
REQ-030 A stop in IDLE SHALL have no effect.
REQ-031 fault=1 in any state SHALL force IGBT to 0 combinationally in the same cycle, then enter FAULT on the next edge.
REQ-032 In FAULT: IGBT=0, busy=0, fault_latch=1, and done SHALL not pulse.
REQ-033 The block SHALL leave FAULT for IDLE only on fault_clr while fault=0.
REQ-034 Apart from the fault gating, IGBT SHALL be a registered output, with at most one bit high at any time.
REQ-035 Simultaneous events SHALL be resolved as:
- fault beats everything else;
- stop with start in IDLE: no run starts;
- cfg_we with start in IDLE: the write is taken and the start is ignored.

Reset
REQ-036 While sys_rst=1 at a clock edge, the block SHALL enter IDLE with IGBT=0, busy=0, done=0, fault_latch=0, cur_ch=0, round counter 0 and stop-pending 0.
REQ-037 Reset SHALL set the config registers to on_time=0, dead_time=0, mask=0 and burst=0.
REQ-038 Reset SHALL override every state, including mid-pulse and FAULT.

Verification
REQ-039 Config mask=5'b10101, on=4, dead=2, burst=1, then start -> IGBT[0], IGBT[2], IGBT[4] each high for 4 cycles with 2-cycle gaps (plus the 1-cycle SELECT between them); done pulses once; no bit overlaps.
REQ-040 mask=5'b00011, on=3, burst=0, then start, then stop during the 2nd pulse of IGBT[1] -> that pulse completes its 3 cycles, then IDLE and done.
REQ-041 fault asserted mid-ON -> IGBT=0 in the same cycle and fault_latch=1; fault_clr while fault=1 -> stays in FAULT; after fault drops, fault_clr -> IDLE.
REQ-042 cfg_we during busy with on=9 -> the pulse width stays at the old value; start with mask=0 -> busy stays 0.
REQ-043 sys_rst mid-pulse -> next cycle IGBT=0 and busy=0; cfg_we and start in the same cycle -> no run starts.
